// File: rtl/fifo_rd.sv
// Read-side controller of the asynchronous FIFO (R_CLK domain): request edge detect,
// binary/Gray read pointers, empty/level flags and registered read data capture.
module fifo_rd #(
  parameter int unsigned ADD_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  rinc,
  input  logic [ADD_WIDTH-1:0]  rq2_wptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rempty,
  output logic [ADD_WIDTH-2:0]  raddr,
  output logic [ADD_WIDTH-1:0]  rptr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [ADD_WIDTH-1:0]  rlevel,
  output logic                  ralmost_empty,
  output logic                  runderflow
);

  localparam logic [ADD_WIDTH-1:0] AeThresh = ADD_WIDTH'(AE_THRESH);
  localparam logic [ADD_WIDTH-1:0] PtrOne   = ADD_WIDTH'(1);

  logic                  rinc_q;
  logic [ADD_WIDTH-1:0]  rbin_q, rbin_d;
  logic [ADD_WIDTH-2:0]  raddr_q, raddr_d;
  logic [ADD_WIDTH-1:0]  rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  runderflow_q, runderflow_d;

  logic                  rinc_pulse;
  logic                  accept;
  logic [ADD_WIDTH-1:0]  rbin_inc;
  logic [ADD_WIDTH-1:0]  wbin;

  assign rinc_pulse = rinc & ~rinc_q;
  assign rempty     = (rptr_q == rq2_wptr);
  assign accept     = rinc_pulse & ~rempty;
  assign rbin_inc   = rbin_q + PtrOne;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int k = 0; k < int'(ADD_WIDTH); k++) begin
      wbin[k] = ^(rq2_wptr >> k);
    end
  end

  always_comb begin
    rbin_d       = rbin_q;
    raddr_d      = raddr_q;
    rptr_d       = rptr_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    runderflow_d = runderflow_q;
    if (accept) begin
      rbin_d   = rbin_inc;
      raddr_d  = rbin_inc[ADD_WIDTH-2:0];
      rptr_d   = rbin_inc ^ (rbin_inc >> 1);
      rdata_d  = mem_rdata;
      rvalid_d = 1'b1;
    end
    if (rinc_pulse && rempty) begin
      runderflow_d = 1'b1;
    end
  end

  // rptr crosses to the write domain, so it must come straight from a flop.
  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      rinc_q       <= 1'b0;
      rbin_q       <= '0;
      raddr_q      <= '0;
      rptr_q       <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      runderflow_q <= 1'b0;
    end else begin
      rinc_q       <= rinc;
      rbin_q       <= rbin_d;
      raddr_q      <= raddr_d;
      rptr_q       <= rptr_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      runderflow_q <= runderflow_d;
    end
  end

  // Modulo subtraction also yields the full count when only the wrap bits differ.
  assign rlevel        = wbin - rbin_q;
  assign ralmost_empty = (rlevel <= AeThresh);

  assign raddr      = raddr_q;
  assign rptr       = rptr_q;
  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign runderflow = runderflow_q;

endmodule
